// File: rtl/imm_gen_stage_pkg.sv
// Shared definitions for the immediate generator stage: format select codes
// and the datapath width legality helper.
package imm_gen_stage_pkg;

  localparam int unsigned IMM_OP_W = 3;

  typedef enum logic [IMM_OP_W-1:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6,
    IMM_SH   = 3'd7
  } imm_op_e;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_gen_stage_ext.sv
// imm_ext_comb: pure combinational immediate extraction and extension to XLEN.
module imm_ext_comb
  import imm_gen_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [IMM_OP_W-1:0] op,
  input  logic [31:0]         inst,
  output logic [XLEN-1:0]     ext
);

  // Every format is first built as a 32-bit value that is already correctly
  // sign/zero extended to 32 bits; Z and SH always have bit 31 clear, so a
  // single signed widening to XLEN is correct for all formats.
  logic [31:0] imm32;

  // Format decode into a 32-bit immediate.
  always_comb begin
    imm32 = '0;
    case (op)
      IMM_NONE: imm32 = '0;
      IMM_I:    imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:    imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:    imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:    imm32 = {inst[31:12], 12'b0};
      IMM_J:    imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_Z:    imm32 = {27'b0, inst[19:15]};
      IMM_SH:   imm32 = (XLEN == 64) ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
      default:  imm32 = '0;
    endcase
  end

  assign ext = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate generator with a 2-entry skid buffer
// (main entry drives out_*, skid entry catches one beat while main stalls).
// Optional feature macro: IMM_TGT_EN adds a buffered in_pc + ext target.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IMM_OP_W-1:0] in_op,
  input  logic [31:0]         in_inst,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_ext,
  output logic [XLEN-1:0]     out_tgt
);

  if (!xlen_legal(XLEN)) begin : g_xlen_bad
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  logic            main_valid;
  logic            skid_valid;
  logic [XLEN-1:0] main_ext;
  logic [XLEN-1:0] skid_ext;
  logic [XLEN-1:0] new_ext;
  logic            in_xfer;
  logic            main_free;
  logic            ld_main_skid;
  logic            ld_main_in;
  logic            ld_skid;

  imm_ext_comb #(.XLEN(XLEN)) u_ext (
    .op   (in_op),
    .inst (in_inst),
    .ext  (new_ext)
  );

  // in_ready depends only on registered skid occupancy and reset, never on out_ready.
  assign in_ready  = ~skid_valid & ~cpu_rst;
  assign in_xfer   = in_valid & in_ready;
  assign main_free = ~main_valid | out_ready;

  // Load enables; flush suppresses every movement. Skid has priority into main
  // to preserve order, and while skid is full in_ready is low so no new beat competes.
  assign ld_main_skid = ~flush & main_free & skid_valid;
  assign ld_main_in   = ~flush & main_free & ~skid_valid & in_xfer;
  assign ld_skid      = ~flush & ~main_free & in_xfer;

  // Entry occupancy; reset and flush empty both entries.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst || flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (main_free) begin
        main_valid <= skid_valid | in_xfer;
      end
      if (ld_skid) begin
        skid_valid <= 1'b1;
      end else if (main_free) begin
        skid_valid <= 1'b0;
      end
    end
  end

  // Immediate payload for both entries.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      main_ext <= '0;
      skid_ext <= '0;
    end else begin
      if (ld_main_skid) begin
        main_ext <= skid_ext;
      end else if (ld_main_in) begin
        main_ext <= new_ext;
      end
      if (ld_skid) begin
        skid_ext <= new_ext;
      end
    end
  end

  assign out_valid = main_valid;
  assign out_ext   = main_ext;

`ifdef IMM_TGT_EN
  logic [XLEN-1:0] new_tgt;
  logic [XLEN-1:0] main_tgt;
  logic [XLEN-1:0] skid_tgt;

  assign new_tgt = in_pc + new_ext;

  // Target payload travels with the immediate through both entries.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      main_tgt <= '0;
      skid_tgt <= '0;
    end else begin
      if (ld_main_skid) begin
        main_tgt <= skid_tgt;
      end else if (ld_main_in) begin
        main_tgt <= new_tgt;
      end
      if (ld_skid) begin
        skid_tgt <= new_tgt;
      end
    end
  end

  assign out_tgt = main_tgt;
`else
  logic unused_pc;
  assign unused_pc = ^in_pc;
  assign out_tgt   = '0;
`endif

endmodule
